// File: rtl/mult_pkg.sv
//==============================================================================
// Module      : mult_pkg
// Description : Shared definitions for the sequential signed/unsigned
//               multiplier: state encoding and a state-decode helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mult_pkg;

    localparam int c_STATE_W = 3;

    // Explicit-width state encoding kept as plain constants so older blocks
    // that compare against raw codes still line up.
    typedef logic [c_STATE_W-1:0] mult_state_t;

    localparam mult_state_t c_IDLE  = 3'd0;
    localparam mult_state_t c_ADD   = 3'd1;
    localparam mult_state_t c_SUB   = 3'd2;
    localparam mult_state_t c_SHIFT = 3'd3;
    localparam mult_state_t c_DONE  = 3'd4;

    // True for the states in which a multiply is in progress.
    function automatic logic state_is_busy(input mult_state_t i_st);
        return (i_st == c_ADD) || (i_st == c_SUB) || (i_st == c_SHIFT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_addsub.sv
//==============================================================================
// Module      : mult_addsub
// Description : (WIDTH+1)-bit adder/subtractor for the partial-product step.
//               Both operands are extended to WIDTH+1 bits, by sign or zero
//               depending on i_sext; subtraction is a + ~b + 1.
// Ports       : i_a    - accumulator operand (WIDTH)
//               i_b    - multiplicand operand (WIDTH)
//               i_sub  - 1: subtract i_b, 0: add i_b
//               i_sext - 1: sign-extend operands, 0: zero-extend
//               o_sum  - WIDTH+1 bit result; MSB becomes the X bit
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mult_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_sext,
    output logic [WIDTH:0]   o_sum
);

    logic [WIDTH:0] w_a_ext;
    logic [WIDTH:0] w_b_ext;
    logic [WIDTH:0] w_b_op;

    assign w_a_ext = {i_sext & i_a[WIDTH-1], i_a};
    assign w_b_ext = {i_sext & i_b[WIDTH-1], i_b};
    assign w_b_op  = i_sub ? ~w_b_ext : w_b_ext;
    assign o_sum   = w_a_ext + w_b_op + {{WIDTH{1'b0}}, i_sub};

endmodule

`default_nettype wire

// File: rtl/seq_mult_n.sv
//==============================================================================
// Module      : seq_mult_n
// Description : Sequential add/shift multiplier, two's-complement by default.
//               The multiplier is loaded into B with Load_B, then Start runs
//               one ADD per set multiplier bit (SUB for the sign bit) and one
//               SHIFT per bit. The 2*WIDTH-bit product ends up in A:B.
//               Latency from Start to Done is WIDTH + popcount(multiplier).
// Options     : MULT_UNSIGNED_MODE_EN - adds the Unsigned_Mode input; when it
//               is 1 at Start, the multiply is unsigned (zero-extend, no SUB,
//               X is the carry-out, logical shift).
// Ports       : Clk, Reset (synchronous, active-high)
//               Start  - level request, sampled in IDLE
//               Load_B - load S into B, clear A and X (IDLE only)
//               S      - multiplicand / multiplier source
//               A, B   - product upper / lower halves
//               X      - extension bit of A
//               Busy   - high in ADD, SUB, SHIFT
//               Done   - high in DONE
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_mult_n
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Load_B,
    input  logic [WIDTH-1:0] S,
`ifdef MULT_UNSIGNED_MODE_EN
    input  logic             Unsigned_Mode,
`endif
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             X,
    output logic             Busy,
    output logic             Done
);

    localparam int c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_SIGN = c_CNT_W'(WIDTH - 1);

    mult_state_t        r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_x;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_uns;

    logic [WIDTH:0]     w_sum;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_uns_in;

`ifdef MULT_UNSIGNED_MODE_EN
    assign w_uns_in = Unsigned_Mode;
`else
    assign w_uns_in = 1'b0;
`endif

    assign w_cnt_inc = r_cnt + 1'b1;

    mult_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a    (r_a),
        .i_b    (S),
        .i_sub  (r_state == c_SUB),
        .i_sext (~r_uns),
        .o_sum  (w_sum)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_x     <= 1'b0;
            r_cnt   <= '0;
            r_uns   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (Load_B) begin
                        r_b <= S;
                        r_a <= '0;
                        r_x <= 1'b0;
                    end else if (Start) begin
                        r_a     <= '0;
                        r_x     <= 1'b0;
                        r_cnt   <= '0;
                        r_uns   <= w_uns_in;
                        r_state <= r_b[0] ? c_ADD : c_SHIFT;
                    end
                end

                c_ADD, c_SUB: begin
                    {r_x, r_a} <= w_sum;
                    r_state    <= c_SHIFT;
                end

                c_SHIFT: begin
                    // X feeds A's MSB in both modes; only the unsigned
                    // (logical) shift clears X afterwards.
                    r_a   <= {r_x, r_a[WIDTH-1:1]};
                    r_b   <= {r_a[0], r_b[WIDTH-1:1]};
                    r_x   <= r_uns ? 1'b0 : r_x;
                    r_cnt <= w_cnt_inc;
                    // r_b[1] is the post-shift B[0]. The last multiplier bit
                    // carries negative weight in two's complement, hence SUB.
                    if (w_cnt_inc == c_CNT_LAST) begin
                        r_state <= c_DONE;
                    end else if (r_b[1]) begin
                        r_state <= ((w_cnt_inc == c_CNT_SIGN) && !r_uns) ? c_SUB : c_ADD;
                    end else begin
                        r_state <= c_SHIFT;
                    end
                end

                c_DONE: begin
                    // Start held high parks here so a level request cannot
                    // trigger a second multiply.
                    if (!Start) begin
                        r_state <= c_IDLE;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign A    = r_a;
    assign B    = r_b;
    assign X    = r_x;
    assign Busy = state_is_busy(r_state);
    assign Done = (r_state == c_DONE);

endmodule

`default_nettype wire

// File: tb/tb_seq_mult_n.sv
//==============================================================================
// Module      : tb_seq_mult_n
// Description : Scoreboard bench for seq_mult_n (WIDTH=8). Directed vectors
//               push expected product, X and Done cycle; a monitor pops and
//               compares on each rising edge of Done.
// Options     : MULT_UNSIGNED_MODE_EN - also exercises the unsigned mode.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_mult_n;

    localparam int WIDTH = 8;

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        logic               x;
        int                 cyc;
    } exp_t;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic             Load_B;
    logic [WIDTH-1:0] S;
    logic             Unsigned_Mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             X;
    logic             Busy;
    logic             Done;

    int   n_cmp;
    int   n_err;
    int   cyc;
    exp_t sb_q[$];

    seq_mult_n #(
        .WIDTH (WIDTH)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Start         (Start),
        .Load_B        (Load_B),
        .S             (S),
`ifdef MULT_UNSIGNED_MODE_EN
        .Unsigned_Mode (Unsigned_Mode),
`endif
        .A             (A),
        .B             (B),
        .X             (X),
        .Busy          (Busy),
        .Done          (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic monitor_loop();
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Done && !prev) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got Done=1 at cycle %0d, expected no transaction", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("product", 32'({A, B}), 32'(e.prod));
                    check("x_bit", 32'(X), 32'(e.x));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            prev = Done;
        end
    endtask

    // One multiply: load multiplier, start with multiplicand, wait for Done,
    // optionally hold Start, then release and confirm return to IDLE.
    task automatic run_mul(input logic [WIDTH-1:0] mb, input logic [WIDTH-1:0] ms,
                           input logic [2*WIDTH-1:0] prod, input logic xv, input int lat,
                           input logic uns, input int hold, input logic pulse_lb);
        exp_t e;
        bit   seen;
        @(posedge Clk); #1;
        Load_B = 1'b1;
        S      = mb;
        @(posedge Clk); #1;
        Load_B        = 1'b0;
        Start         = 1'b1;
        Unsigned_Mode = uns;
        S             = ms;
        e.prod = prod;
        e.x    = xv;
        e.cyc  = cyc + 1 + lat;
        sb_q.push_back(e);
        if (pulse_lb) begin
            repeat (3) @(posedge Clk);
            #1 Load_B = 1'b1;
            @(negedge Clk);
            check("busy_mid_op", 32'(Busy), 32'd1);
            @(posedge Clk); #1;
            Load_B = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge Clk);
            if (Done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no Done in 64 cycles, expected Done");
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            check("hold_done_ab", 32'({Done, A, B}), 32'({1'b1, prod}));
        end
        Start = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("idle_after_release", 32'({Busy, Done}), 32'd0);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        cyc           = 0;
        Reset         = 1'b1;
        Start         = 1'b0;
        Load_B        = 1'b0;
        S             = '0;
        Unsigned_Mode = 1'b0;
        fork
            monitor_loop();
        join_none
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_state", 32'({A, B, X, Busy, Done}), 32'd0);
        #1 Reset = 1'b0;

        //       mb     ms     product   X     lat uns hold pulse
        run_mul(8'h03, 8'h07, 16'h0015, 1'b0, 10, 1'b0, 0, 1'b0);
        run_mul(8'h03, 8'hFE, 16'hFFFA, 1'b1, 10, 1'b0, 0, 1'b0);
        run_mul(8'h80, 8'h03, 16'hFE80, 1'b1,  9, 1'b0, 0, 1'b0);
        run_mul(8'h80, 8'h80, 16'h4000, 1'b0,  9, 1'b0, 0, 1'b0);
        run_mul(8'hFF, 8'hFF, 16'h0001, 1'b0, 16, 1'b0, 0, 1'b0);
        run_mul(8'h00, 8'h5A, 16'h0000, 1'b0,  8, 1'b0, 0, 1'b0);
        run_mul(8'h80, 8'h7F, 16'hC080, 1'b1,  9, 1'b0, 0, 1'b0);
        run_mul(8'h7F, 8'h7F, 16'h3F01, 1'b0, 15, 1'b0, 0, 1'b0);

        // Abort a multiply with Reset during its fifth cycle.
        @(posedge Clk); #1;
        Load_B = 1'b1;
        S      = 8'h03;
        @(posedge Clk); #1;
        Load_B = 1'b0;
        Start  = 1'b1;
        S      = 8'h07;
        repeat (4) @(posedge Clk);
        #1;
        Reset = 1'b1;
        Start = 1'b0;
        @(negedge Clk);
        check("busy_before_reset", 32'(Busy), 32'd1);
        @(negedge Clk);
        check("reset_mid_op", 32'({A, B, X, Busy, Done}), 32'd0);
        #1 Reset = 1'b0;

        // Start held after Done, Load_B pulsed while busy.
        run_mul(8'h05, 8'h05, 16'h0019, 1'b0, 10, 1'b0, 20, 1'b1);
        run_mul(8'hFD, 8'h06, 16'hFFEE, 1'b1, 15, 1'b0, 0, 1'b0);

`ifdef MULT_UNSIGNED_MODE_EN
        run_mul(8'hFF, 8'hFF, 16'hFE01, 1'b0, 16, 1'b1, 0, 1'b0);
        run_mul(8'h80, 8'h03, 16'h0180, 1'b0,  9, 1'b1, 0, 1'b0);
`endif

        repeat (5) @(negedge Clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_mult_n.md
SEQ_MULT_N -- requirements
Module: seq_mult_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal range 2..32.
REQ-002 SHALL have port Clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port Start  input  1  level request to begin a multiply; sampled in IDLE.
REQ-005 SHALL have port Load_B  input  1  load S into B and clear A and X; honoured in IDLE only.
REQ-006 SHALL have port S  input  WIDTH  multiplicand, and multiplier source for Load_B.
REQ-007 SHALL have port A  output  WIDTH  product upper half.
REQ-008 SHALL have port B  output  WIDTH  multiplier register; holds the product lower half when done.
REQ-009 SHALL have port X  output  1  sign/extension bit of A.
REQ-010 SHALL have port Busy  output  1  high in ADD, SUB and SHIFT.
REQ-011 SHALL have port Done  output  1  high in DONE.

Function
REQ-012 SHALL implement states IDLE, ADD, SUB, SHIFT and DONE, with an internal shift counter cnt of width $clog2(WIDTH)+1.
REQ-013 SHALL, in IDLE, treat Load_B as having priority over Start:
- Load_B=1: B<=S, A<=0, X<=0, remain in IDLE.
- Else Start=1: A<=0, X<=0, cnt<=0, go to ADD if B[0]=1 and WIDTH>1, otherwise go to SHIFT.
REQ-014 SHALL, in ADD, perform {X,A} <= sext(A) + sext(S), computed at WIDTH+1 bits, then go to SHIFT.
REQ-015 SHALL, in SUB, perform {X,A} <= sext(A) - sext(S) (computed as A + ~S + 1), then go to SHIFT.
REQ-016 SHALL, in SHIFT, perform an arithmetic right shift of {X,A,B} by one (X kept, A[0] into B[WIDTH-1]) and set cnt<=cnt+1.
REQ-017 SHALL select the next state after SHIFT using the post-shift B[0]:
- cnt+1==WIDTH: go to DONE.
- cnt+1==WIDTH-1 and B[0]=1: go to SUB.
- Other B[0]=1: go to ADD.
- Otherwise: stay in SHIFT.
REQ-018 SHALL hold in DONE, with A:B holding the signed 2*WIDTH-bit product, until Start==0, then go to IDLE; Start held high never restarts a multiply.
REQ-019 SHALL give a latency from Start sampled to Done high of WIDTH + popcount(multiplier) cycles.
REQ-020 SHALL ignore S changes except in the ADD, SUB and Load_B cycles, and SHALL ignore Load_B outside IDLE.
REQ-021 SHALL, when Reset and any other input coincide, give Reset priority.

Reset
REQ-022 SHALL, on Reset in any state including mid-operation, set state to IDLE, A=0, B=0, X=0, cnt=0, Busy=0, Done=0 on the next edge.
REQ-023 SHALL allow a multiply to start with Load_B and Start one cycle after Reset deasserts.

Configuration
REQ-024 SHALL, when MULT_UNSIGNED_MODE_EN is defined, add port Unsigned_Mode (input, 1 bit), which is sampled in IDLE with Start and held for the whole operation.
REQ-025 SHALL, with the macro defined and Unsigned_Mode=1:
- Use zero-extension in ADD.
- Replace SUB with ADD.
- Make X the carry-out.
- Use a logical shift for SHIFT (X into A MSB, then X<=0).
REQ-026 SHALL, when MULT_UNSIGNED_MODE_EN is undefined, have no Unsigned_Mode port and operate signed only.

Structure
REQ-027 SHALL take typedef mult_state_t (IDLE, ADD, SUB, SHIFT, DONE) from shared package mult_pkg.
REQ-028 SHALL instantiate one sub-module, mult_addsub: a (WIDTH+1)-bit add/subtract with sub and sign-extension-select inputs.

Verification
REQ-029 SHALL cover, WIDTH=8: Load_B S=0x03, Start S=0x07 -> Done after 10 cycles, A=0x00, B=0x15, X=0.
REQ-030 SHALL cover: Load_B 0x03, Start S=0xFE -> A:B=0xFFFA, X=1.
REQ-031 SHALL cover: Load_B 0x80, Start S=0x03 -> A:B=0xFE80 via the SUB path; also Load_B 0x80 with S=0x80 -> A:B=0x4000.
REQ-032 SHALL cover: Reset asserted in cycle 5 of an operation -> next cycle all outputs 0 and state IDLE; a following multiply is correct.
REQ-033 SHALL cover: Start held 20 cycles after Done -> Done stays 1 and A:B is unchanged; Start low -> IDLE next cycle; Load_B pulsed while Busy -> ignored.
REQ-034 SHALL cover, with MULT_UNSIGNED_MODE_EN and Unsigned_Mode=1: Load_B 0xFF, Start S=0xFF -> A:B=0xFE01.
